// File: rtl/safe_seq_ctrl.sv
// Safe sequencer: debounced ENTER_N drives a SET/LOCKED/CHECK/OPEN/LOCKOUT
// FSM that strobes the password/attempt registers and enforces a lockout.
module safe_seq_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned MAX_FAILS       = 3,
  parameter int unsigned LOCKOUT_CYCLES  = 50000000
) (
  input  logic       clk,
  input  logic       RESETN,
  input  logic       ENTER_N,
  input  logic       MATCH,
  output logic       save_pw,
  output logic       save_at,
  output logic [2:0] state,
  output logic       is_open,
  output logic [2:0] fail_cnt,
  output logic       lockout
);

  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned TW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TM_LOAD  = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [2:0]    FAIL_MAX = 3'(MAX_FAILS);

  localparam logic [2:0] ST_SET     = 3'b000;
  localparam logic [2:0] ST_LOCKED  = 3'b001;
  localparam logic [2:0] ST_CHECK   = 3'b010;
  localparam logic [2:0] ST_OPEN    = 3'b011;
  localparam logic [2:0] ST_LOCKOUT = 3'b100;

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]    init_q, init_d;
  logic          armed_q, armed_d;
  logic          press_q, press_d;
  logic [2:0]    state_q, state_d;
  logic [2:0]    fail_q, fail_d;
  logic [TW-1:0] timer_q, timer_d;

  // Debounce and press detection. The synchronizer resets to "released", so
  // init_q waits two cycles before trusting sync2_q; a fall of the debounced
  // level only counts once a genuine release has been seen since reset.
  always_comb begin
    sync1_d  = ENTER_N;
    sync2_d  = sync1_q;
    level_d  = level_q;
    db_cnt_d = '0;
    if (sync2_q != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
    init_d  = {init_q[0], 1'b1};
    armed_d = armed_q | (init_q[1] & sync2_q);
    press_d = armed_q & level_q & ~level_d;
  end

  always_comb begin
    state_d = state_q;
    fail_d  = fail_q;
    timer_d = timer_q;
    case (state_q)
      ST_SET: begin
        if (press_q) state_d = ST_LOCKED;
      end
      ST_LOCKED: begin
        if (press_q) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (MATCH) begin
          state_d = ST_OPEN;
          fail_d  = '0;
        end else begin
          fail_d = (fail_q >= FAIL_MAX) ? FAIL_MAX : fail_q + 3'd1;
          if (fail_d == FAIL_MAX) begin
            state_d = ST_LOCKOUT;
            timer_d = TM_LOAD;
          end else begin
            state_d = ST_LOCKED;
          end
        end
      end
      ST_OPEN: begin
        if (press_q) begin
          state_d = ST_SET;
          fail_d  = '0;
        end
      end
      ST_LOCKOUT: begin
        if (timer_q == '0) begin
          state_d = ST_LOCKED;
          fail_d  = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_SET;
        fail_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge RESETN) begin
    if (!RESETN) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      level_q  <= 1'b1;
      db_cnt_q <= '0;
      init_q   <= '0;
      armed_q  <= 1'b0;
      press_q  <= 1'b0;
      state_q  <= ST_SET;
      fail_q   <= '0;
      timer_q  <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      level_q  <= level_d;
      db_cnt_q <= db_cnt_d;
      init_q   <= init_d;
      armed_q  <= armed_d;
      press_q  <= press_d;
      state_q  <= state_d;
      fail_q   <= fail_d;
      timer_q  <= timer_d;
    end
  end

  assign save_pw  = press_q & (state_q == ST_SET);
  assign save_at  = press_q & (state_q == ST_LOCKED);
  assign state    = state_q;
  assign is_open  = (state_q == ST_OPEN);
  assign lockout  = (state_q == ST_LOCKOUT);
  assign fail_cnt = fail_q;

endmodule

// File: tb/tb_safe_seq_ctrl.sv
// Bench for safe_seq_ctrl: per-scenario tasks, random attempts and hold
// times, expectations from a per-attempt model of the lock's rules.
module tb_safe_seq_ctrl;

  localparam int MAXF = 3;
  localparam logic [2:0] S_SET = 3'd0, S_LOCKED = 3'd1, S_CHECK = 3'd2,
                         S_OPEN = 3'd3, S_LOCKOUT = 3'd4;

  logic       clk = 1'b0;
  logic       RESETN;
  logic       ENTER_N;
  logic       MATCH;
  logic       save_pw, save_at, is_open, lockout;
  logic [2:0] state, fail_cnt;

  int checks = 0;
  int failures = 0;

  logic [2:0] m_state;
  logic [2:0] m_fail;

  logic [2:0] st_q[$];
  logic [2:0] fc_q[$];
  logic       pw_q[$];
  logic       at_q[$];
  logic       op_q[$];
  logic       lo_q[$];

  safe_seq_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .MAX_FAILS(3),
    .LOCKOUT_CYCLES(10)
  ) dut (
    .clk(clk),
    .RESETN(RESETN),
    .ENTER_N(ENTER_N),
    .MATCH(MATCH),
    .save_pw(save_pw),
    .save_at(save_at),
    .state(state),
    .is_open(is_open),
    .fail_cnt(fail_cnt),
    .lockout(lockout)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      st_q.push_back(state);
      fc_q.push_back(fail_cnt);
      pw_q.push_back(save_pw);
      at_q.push_back(save_at);
      op_q.push_back(is_open);
      lo_q.push_back(lockout);
    end
  endtask

  task automatic clear_log();
    st_q.delete(); fc_q.delete(); pw_q.delete();
    at_q.delete(); op_q.delete(); lo_q.delete();
  endtask

  task automatic apply_reset();
    ENTER_N = 1'b1;
    @(posedge clk); #2;
    RESETN = 1'b0;
    @(posedge clk); #2;
    RESETN = 1'b1;
    tick(4);
    m_state = S_SET;
    m_fail  = 3'd0;
  endtask

  // One button press (optionally followed by a second press that must land in
  // lockout), checked against the model's view of what the attempt should do.
  task automatic do_press(input int hold, input logic match, input bit repress, input string tag);
    int exp_pw, exp_at, npw, nat, idx, bad, f, last, lbad;
    logic [2:0] nxt_state, nxt_fail;
    bit to_lockout;
    exp_pw = 0; exp_at = 0; to_lockout = 0;
    nxt_state = m_state; nxt_fail = m_fail;
    case (m_state)
      S_SET: begin exp_pw = 1; nxt_state = S_LOCKED; end
      S_LOCKED: begin
        exp_at = 1;
        if (match) begin
          nxt_state = S_OPEN; nxt_fail = 3'd0;
        end else begin
          f = int'(m_fail) + 1;
          if (f > MAXF) f = MAXF;
          nxt_fail = 3'(f);
          if (f == MAXF) begin to_lockout = 1; nxt_state = S_LOCKOUT; end
          else nxt_state = S_LOCKED;
        end
      end
      S_OPEN: nxt_state = S_SET;
      default: ;
    endcase

    clear_log();
    MATCH = match;
    ENTER_N = 1'b0;
    if (repress) begin
      tick(4); ENTER_N = 1'b1; tick(5); ENTER_N = 1'b0; tick(4); ENTER_N = 1'b1; tick(12);
    end else begin
      tick(hold); ENTER_N = 1'b1; tick(16);
    end

    npw = 0; nat = 0; idx = -1; bad = 0;
    for (int i = 0; i < st_q.size(); i++) begin
      if (pw_q[i] === 1'b1) npw++;
      if (at_q[i] === 1'b1) nat++;
      if (idx < 0 && (pw_q[i] === 1'b1 || at_q[i] === 1'b1)) idx = i;
      if (pw_q[i] === 1'b1 && st_q[i] !== S_SET) bad++;
      if (at_q[i] === 1'b1 && st_q[i] !== S_LOCKED) bad++;
      if (pw_q[i] === 1'b1 && at_q[i] === 1'b1) bad++;
    end

    checks++;
    if (npw !== exp_pw) begin failures++; $display("FAIL %s save_pw_count got=%0d exp=%0d", tag, npw, exp_pw); end
    checks++;
    if (nat !== exp_at) begin failures++; $display("FAIL %s save_at_count got=%0d exp=%0d", tag, nat, exp_at); end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL %s strobe_outside_state got=%0d exp=0", tag, bad); end
    if (exp_pw + exp_at > 0) begin
      checks++;
      if (idx < 4 || idx > 6) begin failures++; $display("FAIL %s strobe_latency got=%0d exp=4..6", tag, idx); end
    end

    if (exp_at == 1 && idx >= 0 && idx + 12 < st_q.size()) begin
      checks++;
      if (st_q[idx+1] !== S_CHECK) begin failures++; $display("FAIL %s check_state got=%0d exp=%0d", tag, st_q[idx+1], S_CHECK); end
      checks++;
      if (st_q[idx+2] !== nxt_state) begin failures++; $display("FAIL %s after_check_state got=%0d exp=%0d", tag, st_q[idx+2], nxt_state); end
      checks++;
      if (fc_q[idx+2] !== nxt_fail) begin failures++; $display("FAIL %s after_check_fail_cnt got=%0d exp=%0d", tag, fc_q[idx+2], nxt_fail); end
      checks++;
      if (op_q[idx+2] !== (nxt_state == S_OPEN)) begin failures++; $display("FAIL %s after_check_is_open got=%0d exp=%0d", tag, op_q[idx+2], nxt_state == S_OPEN); end
      if (to_lockout) begin
        lbad = 0;
        for (int k = idx + 2; k <= idx + 11; k++)
          if (st_q[k] !== S_LOCKOUT || lo_q[k] !== 1'b1) lbad++;
        checks++;
        if (lbad !== 0) begin failures++; $display("FAIL %s lockout_duration bad_cycles got=%0d exp=0", tag, lbad); end
        checks++;
        if (st_q[idx+12] !== S_LOCKED) begin failures++; $display("FAIL %s lockout_exit_state got=%0d exp=%0d", tag, st_q[idx+12], S_LOCKED); end
        checks++;
        if (fc_q[idx+12] !== 3'd0) begin failures++; $display("FAIL %s lockout_exit_fail_cnt got=%0d exp=0", tag, fc_q[idx+12]); end
        nxt_state = S_LOCKED;
        nxt_fail  = 3'd0;
      end
    end

    last = st_q.size() - 1;
    checks++;
    if (st_q[last] !== nxt_state) begin failures++; $display("FAIL %s final_state got=%0d exp=%0d", tag, st_q[last], nxt_state); end
    checks++;
    if (fc_q[last] !== nxt_fail) begin failures++; $display("FAIL %s final_fail_cnt got=%0d exp=%0d", tag, fc_q[last], nxt_fail); end
    checks++;
    if (op_q[last] !== (nxt_state == S_OPEN)) begin failures++; $display("FAIL %s final_is_open got=%0d exp=%0d", tag, op_q[last], nxt_state == S_OPEN); end
    checks++;
    if (lo_q[last] !== 1'b0) begin failures++; $display("FAIL %s final_lockout got=%0d exp=0", tag, lo_q[last]); end
    m_state = nxt_state;
    m_fail  = nxt_fail;
  endtask

  task automatic test_reset();
    RESETN = 1'b0; ENTER_N = 1'b1; MATCH = 1'b0;
    #3;
    checks++; if (state !== S_SET) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (fail_cnt !== 3'd0) begin failures++; $display("FAIL reset_fail_cnt got=%0d exp=0", fail_cnt); end
    checks++; if (save_pw !== 1'b0) begin failures++; $display("FAIL reset_save_pw got=%0d exp=0", save_pw); end
    checks++; if (save_at !== 1'b0) begin failures++; $display("FAIL reset_save_at got=%0d exp=0", save_at); end
    checks++; if (is_open !== 1'b0) begin failures++; $display("FAIL reset_is_open got=%0d exp=0", is_open); end
    checks++; if (lockout !== 1'b0) begin failures++; $display("FAIL reset_lockout got=%0d exp=0", lockout); end
    @(posedge clk); #2;
    RESETN = 1'b1;
    clear_log();
    tick(6);
    checks++; if (st_q[5] !== S_SET || pw_q[5] !== 1'b0) begin failures++; $display("FAIL reset_idle state got=%0d exp=0", st_q[5]); end
    m_state = S_SET; m_fail = 3'd0;
  endtask

  task automatic test_first_press();
    do_press(6, 1'b0, 1'b0, "first_press");
    do_press(20, 1'b1, 1'b0, "held_attempt");
    do_press($urandom_range(6, 12), 1'b1, 1'b0, "open_to_set");
  endtask

  task automatic test_bounce();
    int n, bad;
    logic [2:0] s0;
    s0 = m_state;
    clear_log();
    for (int i = 0; i < 10; i++) begin
      ENTER_N = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick(2);
    end
    ENTER_N = 1'b1; tick(10);
    for (int i = 0; i < 15; i++) begin
      ENTER_N = ~ENTER_N;
      tick($urandom_range(1, 3));
    end
    ENTER_N = 1'b1; tick(10);
    n = 0; bad = 0;
    for (int i = 0; i < st_q.size(); i++) begin
      if (pw_q[i] === 1'b1 || at_q[i] === 1'b1) n++;
      if (st_q[i] !== s0) bad++;
    end
    checks++; if (n !== 0) begin failures++; $display("FAIL bounce_strobes got=%0d exp=0", n); end
    checks++; if (bad !== 0) begin failures++; $display("FAIL bounce_state_changes got=%0d exp=0", bad); end
  endtask

  task automatic test_open();
    apply_reset();
    do_press(7, 1'b0, 1'b0, "open_set");
    do_press($urandom_range(6, 10), 1'b1, 1'b0, "open_match");
    do_press($urandom_range(6, 10), 1'b0, 1'b0, "open_leave");
  endtask

  task automatic test_lockout();
    apply_reset();
    do_press(6, 1'b1, 1'b0, "lk_set");
    do_press($urandom_range(6, 10), 1'b0, 1'b0, "lk_wrong1");
    do_press($urandom_range(6, 10), 1'b0, 1'b0, "lk_wrong2");
    do_press(4, 1'b0, 1'b1, "lk_wrong3_repress");
    do_press($urandom_range(6, 10), 1'b1, 1'b0, "lk_after_exit");
  endtask

  task automatic test_recover();
    apply_reset();
    do_press(6, 1'b0, 1'b0, "rc_set");
    do_press(8, 1'b0, 1'b0, "rc_wrong1");
    do_press(8, 1'b0, 1'b0, "rc_wrong2");
    do_press(8, 1'b1, 1'b0, "rc_correct");
  endtask

  task automatic test_reset_mid_lockout();
    int w;
    apply_reset();
    do_press(6, 1'b0, 1'b0, "rm_set");
    do_press(6, 1'b0, 1'b0, "rm_wrong1");
    do_press(6, 1'b0, 1'b0, "rm_wrong2");
    clear_log();
    MATCH = 1'b0; ENTER_N = 1'b0;
    w = 0;
    while (state !== S_LOCKOUT && w < 30) begin tick(1); w++; end
    checks++;
    if (state !== S_LOCKOUT) begin failures++; $display("FAIL rm_reach_lockout got=%0d exp=4", state); end
    ENTER_N = 1'b1;
    tick(4);
    RESETN = 1'b0;
    #1;
    checks++; if (state !== S_SET) begin failures++; $display("FAIL rm_async_state got=%0d exp=0", state); end
    checks++; if (lockout !== 1'b0) begin failures++; $display("FAIL rm_async_lockout got=%0d exp=0", lockout); end
    checks++; if (fail_cnt !== 3'd0) begin failures++; $display("FAIL rm_async_fail_cnt got=%0d exp=0", fail_cnt); end
    checks++; if (is_open !== 1'b0 || save_pw !== 1'b0 || save_at !== 1'b0) begin failures++; $display("FAIL rm_async_flags got=%0d exp=0", {is_open, save_pw, save_at}); end
    @(posedge clk); #2;
    RESETN = 1'b1;
    clear_log();
    tick(12);
    checks++; if (st_q[11] !== S_SET) begin failures++; $display("FAIL rm_after_release_state got=%0d exp=0", st_q[11]); end
    m_state = S_SET; m_fail = 3'd0;
    do_press(6, 1'b0, 1'b0, "rm_fresh_press");
  endtask

  task automatic test_held_through_reset();
    int n;
    ENTER_N = 1'b0;
    @(posedge clk); #2;
    RESETN = 1'b0;
    @(posedge clk); #2;
    RESETN = 1'b1;
    m_state = S_SET; m_fail = 3'd0;
    clear_log();
    tick(20);
    n = 0;
    for (int i = 0; i < st_q.size(); i++) if (pw_q[i] === 1'b1) n++;
    checks++; if (n !== 0) begin failures++; $display("FAIL held_reset_no_event got=%0d exp=0", n); end
    checks++; if (st_q[19] !== S_SET) begin failures++; $display("FAIL held_reset_state got=%0d exp=0", st_q[19]); end
    ENTER_N = 1'b1;
    tick(10);
    do_press(6, 1'b0, 1'b0, "held_reset_repress");
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 40; i++)
      do_press($urandom_range(6, 20), 1'($urandom_range(0, 1)), 1'b0, "random");
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_first_press();
    test_open();
    test_lockout();
    test_recover();
    test_reset_mid_lockout();
    test_held_through_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
